pool_window_feeder: RTL and testbench

//   Producer side of the pooling stream. Accepts a raster-scan feature map one pixel at a time.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/pool_line_buffer.sv | 28 ++
 rtl/pool_window_feeder.sv | 125 ++++++++++++
 tb/tb_pool_window_feeder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types for the pooling stream: window element count, feeder FSM states.
// Pure declarations; no logic, no latency, no flow control.
package cnn_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int WIN_ELEMS      = 4;

  typedef enum logic {
    ACCEPT = 1'b0,
    EMIT   = 1'b1
  } state_t;

  typedef logic [$clog2(WIN_ELEMS)-1:0] idx_t;

endpackage

// File: rtl/pool_line_buffer.sv
// One-row pixel store: a single write port plus two combinational reads (col-1, col).
// Write lands on the clock edge; reads are same-cycle. No flow control of its own.
module pool_line_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/pool_window_feeder.sv
// Regroups a raster pixel stream into 2x2 windows emitted TL,TR,BL,BR; win_valid rises one
// edge after the BR pixel; input is stalled for the whole emission (no skid buffer).
module pool_window_feeder
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] win_data,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic                     win_last,
  output logic                     frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam idx_t             IDX_LAST = idx_t'(WIN_ELEMS - 1);

  state_t                     state;
  logic [COL_W-1:0]           col;
  logic [COL_W-1:0]           col_prev;
  logic [ROW_W-1:0]           row;
  idx_t                       idx;
  idx_t                       idx_nxt;
  logic signed [DATA_W-1:0]   bl_reg;
  logic signed [DATA_W-1:0]   win_elem [WIN_ELEMS];
  logic [DATA_W-1:0]          lb_prev;
  logic [DATA_W-1:0]          lb_cur;
  logic                       last_win;
  logic                       in_xfer;
  logic                       lb_we;

  assign in_xfer  = in_valid & in_ready;
  assign lb_we    = in_xfer & ~row[0];
  assign col_prev = col - 1'b1;
  assign idx_nxt  = idx + 1'b1;

  pool_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_line_buf (
    .clk       (clk),
    .wr_addr   (col),
    .wr_data   (in_data),
    .wr_en     (lb_we),
    .rd_addr_a (col_prev),
    .rd_data_a (lb_prev),
    .rd_addr_b (col),
    .rd_data_b (lb_cur)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCEPT;
      in_ready   <= 1'b0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      win_data   <= '0;
      frame_done <= 1'b0;
      col        <= '0;
      row        <= '0;
      idx        <= '0;
      bl_reg     <= '0;
      last_win   <= 1'b0;
      for (int i = 0; i < WIN_ELEMS; i++) win_elem[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ACCEPT: begin
          in_ready <= 1'b1;
          if (in_xfer) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (row[0] && !col[0]) begin
              bl_reg <= in_data;
            end else if (row[0] && col[0]) begin
              // BR pixel closes the window: the upper row still sits in the line buffer.
              win_elem[0] <= lb_prev;
              win_elem[1] <= lb_cur;
              win_elem[2] <= bl_reg;
              win_elem[3] <= in_data;
              win_data    <= lb_prev;
              win_last    <= 1'b0;
              win_valid   <= 1'b1;
              in_ready    <= 1'b0;
              idx         <= '0;
              last_win    <= (row == ROW_LAST) && (col == COL_LAST);
              state       <= EMIT;
            end
          end
        end
        EMIT: begin
          if (win_ready) begin
            if (idx == IDX_LAST) begin
              state      <= ACCEPT;
              win_valid  <= 1'b0;
              win_last   <= 1'b0;
              in_ready   <= 1'b1;
              frame_done <= last_win;
            end else begin
              idx      <= idx_nxt;
              win_data <= win_elem[idx_nxt];
              win_last <= (idx_nxt == IDX_LAST);
            end
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench: 4x4 frames through one feeder, a signed 2x2 frame through a second.
module tb_pool_window_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] in_data, win_data;
  logic        in_valid, in_ready, win_valid, win_ready, win_last, frame_done;
  logic [31:0] b_in_data, b_win_data;
  logic        b_in_valid, b_in_ready, b_win_valid, b_win_ready, b_win_last, b_frame_done;

  int errors = 0;
  int checks = 0;
  int win_mode = 0;  // 0: always ready, 1: toggle each cycle, 2: driven by the test

  int exp_seq [16] = '{1, 2, 5, 6, 3, 4, 7, 8, 9, 10, 13, 14, 11, 12, 15, 16};

  logic [31:0] q_data [$];
  logic        q_last [$];
  int          fd_pos [$];
  int          fd_cnt, fd_wide, hold_err, hold_seen, rdy_viol;
  logic        fd_prev, hold_pend, hold_l;
  logic [31:0] hold_d;

  logic [31:0] qb_data [$];
  logic        qb_last [$];
  int          b_fd_cnt = 0;

  pool_window_feeder #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready), .win_last(win_last),
    .frame_done(frame_done)
  );

  pool_window_feeder #(.DATA_W(32), .IMG_W(2), .IMG_H(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .win_data(b_win_data), .win_valid(b_win_valid), .win_ready(b_win_ready), .win_last(b_win_last),
    .frame_done(b_frame_done)
  );

  always @(negedge clk) begin
    if (hold_pend && win_valid) begin
      hold_seen++;
      if (win_data !== hold_d || win_last !== hold_l) hold_err++;
    end
    hold_pend = win_valid && !win_ready;
    hold_d    = win_data;
    hold_l    = win_last;
    if (win_valid && win_ready) begin
      q_data.push_back(win_data);
      q_last.push_back(win_last);
    end
    if (win_valid && in_ready) rdy_viol++;
    if (frame_done) begin
      fd_cnt++;
      fd_pos.push_back(q_data.size());
      if (fd_prev) fd_wide++;
    end
    fd_prev = frame_done;
  end

  always @(negedge clk) begin
    if (b_win_valid && b_win_ready) begin
      qb_data.push_back(b_win_data);
      qb_last.push_back(b_win_last);
    end
    if (b_frame_done) b_fd_cnt++;
  end

  initial begin
    win_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (win_mode == 0) win_ready = 1'b1;
      else if (win_mode == 1) win_ready = ~win_ready;
    end
  end

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    fd_pos.delete();
    fd_cnt = 0; fd_wide = 0; hold_err = 0; hold_seen = 0; rdy_viol = 0;
    fd_prev = 1'b0; hold_pend = 1'b0;
  endtask

  task automatic send_seq(input int start, input int n, input bit gap);
    for (int k = start; k < start + n; k++) begin
      int  cyc;
      bit  acc;
      in_data  = (k % 16) + 1;
      in_valid = 1'b1;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL send_timeout: pixel %0d in_ready=%b required 1", k, in_ready);
      end
      in_valid = 1'b0;
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_elems(input int n);
    int cyc = 0;
    while (q_data.size() < n && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (q_data.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_timeout: got %0d elements required %0d", q_data.size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_win_ready = 1'b1;
    clear_mon();
    #12;
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    checks++; if (win_valid !== 1'b0)  begin errors++; $display("FAIL rst_win_valid: got %b required 0", win_valid); end
    checks++; if (win_last !== 1'b0)   begin errors++; $display("FAIL rst_win_last: got %b required 0", win_last); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
    checks++; if (win_data !== 32'd0)  begin errors++; $display("FAIL rst_win_data: got %0d required 0", win_data); end
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL rst_b_in_ready: got %b required 0", b_in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL post_rst_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_basic();
    clear_mon();
    win_mode = 0;
    send_seq(0, 16, 1'b0);
    wait_elems(16);
    checks++; if (q_data.size() !== 16) begin errors++; $display("FAIL basic_count: got %0d required 16", q_data.size()); end
    for (int k = 0; k < 16 && k < q_data.size(); k++) begin
      checks++; if (q_data[k] !== exp_seq[k]) begin errors++; $display("FAIL basic_data[%0d]: got %0d required %0d", k, q_data[k], exp_seq[k]); end
      checks++; if (q_last[k] !== (k % 4 == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %b required %b", k, q_last[k], (k % 4 == 3)); end
    end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL basic_fd_count: got %0d required 1", fd_cnt); end
    checks++; if (fd_pos.size() < 1 || fd_pos[0] !== 16) begin errors++; $display("FAIL basic_fd_pos: got %0d required 16", (fd_pos.size() > 0) ? fd_pos[0] : -1); end
    checks++; if (rdy_viol !== 0) begin errors++; $display("FAIL basic_in_ready_in_emit: got %0d cycles required 0", rdy_viol); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    win_mode = 1;
    send_seq(0, 16, 1'b0);
    wait_elems(16);
    win_mode = 0;
    checks++; if (q_data.size() !== 16) begin errors++; $display("FAIL bp_count: got %0d required 16", q_data.size()); end
    for (int k = 0; k < 16 && k < q_data.size(); k++) begin
      checks++; if (q_data[k] !== exp_seq[k]) begin errors++; $display("FAIL bp_data[%0d]: got %0d required %0d", k, q_data[k], exp_seq[k]); end
      checks++; if (q_last[k] !== (k % 4 == 3)) begin errors++; $display("FAIL bp_last[%0d]: got %b required %b", k, q_last[k], (k % 4 == 3)); end
    end
    checks++; if (hold_seen == 0) begin errors++; $display("FAIL bp_stalls_seen: got %0d required >0", hold_seen); end
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL bp_hold_stable: got %0d unstable cycles required 0", hold_err); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL bp_fd_count: got %0d required 1", fd_cnt); end
  endtask

  task automatic test_in_gaps();
    clear_mon();
    win_mode = 0;
    send_seq(0, 16, 1'b1);
    wait_elems(16);
    checks++; if (q_data.size() !== 16) begin errors++; $display("FAIL gap_count: got %0d required 16", q_data.size()); end
    for (int k = 0; k < 16 && k < q_data.size(); k++) begin
      checks++; if (q_data[k] !== exp_seq[k]) begin errors++; $display("FAIL gap_data[%0d]: got %0d required %0d", k, q_data[k], exp_seq[k]); end
    end
    checks++; if (rdy_viol !== 0) begin errors++; $display("FAIL gap_in_ready_in_emit: got %0d cycles required 0", rdy_viol); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL gap_fd_count: got %0d required 1", fd_cnt); end
  endtask

  task automatic test_signed();
    int vals [4] = '{-5, -6, -7, -8};
    int cyc;
    qb_data.delete();
    qb_last.delete();
    b_fd_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      bit acc = 1'b0;
      b_in_data  = vals[k];
      b_in_valid = 1'b1;
      cyc = 0;
      while (!acc && cyc < 200) begin
        @(negedge clk);
        acc = b_in_ready;
        @(posedge clk);
        #1;
        cyc++;
      end
      b_in_valid = 1'b0;
    end
    cyc = 0;
    while (qb_data.size() < 4 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (qb_data.size() !== 4) begin errors++; $display("FAIL signed_count: got %0d required 4", qb_data.size()); end
    for (int k = 0; k < 4 && k < qb_data.size(); k++) begin
      checks++; if ($signed(qb_data[k]) !== vals[k]) begin errors++; $display("FAIL signed_data[%0d]: got %0d required %0d", k, $signed(qb_data[k]), vals[k]); end
      checks++; if (qb_last[k] !== (k == 3)) begin errors++; $display("FAIL signed_last[%0d]: got %b required %b", k, qb_last[k], (k == 3)); end
    end
    checks++; if (b_fd_cnt !== 1) begin errors++; $display("FAIL signed_fd_count: got %0d required 1", b_fd_cnt); end
  endtask

  task automatic test_reset_mid_emit();
    clear_mon();
    win_mode = 0;
    send_seq(0, 7, 1'b0);
    win_mode = 2;
    win_ready = 1'b0;
    send_seq(7, 1, 1'b0);
    checks++; if (win_valid !== 1'b1 || win_data !== 32'd3) begin errors++; $display("FAIL mid_win2_start: valid=%b data=%0d required valid=1 data=3", win_valid, win_data); end
    win_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    win_ready = 1'b0;
    checks++; if (win_data !== 32'd7 || win_last !== 1'b0) begin errors++; $display("FAIL mid_win2_idx2: data=%0d last=%b required data=7 last=0", win_data, win_last); end
    rst_n = 1'b0;
    #1;
    checks++; if (win_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_async: valid=%b in_ready=%b required 0 0", win_valid, in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    win_mode = 0;
    send_seq(0, 16, 1'b0);
    wait_elems(16);
    checks++; if (q_data.size() !== 16) begin errors++; $display("FAIL mid_count: got %0d required 16", q_data.size()); end
    for (int k = 0; k < 16 && k < q_data.size(); k++) begin
      checks++; if (q_data[k] !== exp_seq[k]) begin errors++; $display("FAIL mid_data[%0d]: got %0d required %0d", k, q_data[k], exp_seq[k]); end
    end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL mid_fd_count: got %0d required 1", fd_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    win_mode = 0;
    send_seq(0, 32, 1'b0);
    wait_elems(32);
    checks++; if (q_data.size() !== 32) begin errors++; $display("FAIL b2b_count: got %0d required 32", q_data.size()); end
    for (int k = 0; k < 32 && k < q_data.size(); k++) begin
      checks++; if (q_data[k] !== exp_seq[k % 16]) begin errors++; $display("FAIL b2b_data[%0d]: got %0d required %0d", k, q_data[k], exp_seq[k % 16]); end
    end
    checks++; if (fd_cnt !== 2) begin errors++; $display("FAIL b2b_fd_count: got %0d required 2", fd_cnt); end
    checks++; if (fd_pos.size() < 2 || fd_pos[0] !== 16 || fd_pos[1] !== 32) begin errors++; $display("FAIL b2b_fd_pos: got %0d entries required pulses after 16 and 32", fd_pos.size()); end
    checks++; if (fd_wide !== 0) begin errors++; $display("FAIL b2b_fd_width: got %0d wide pulses required 0", fd_wide); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_in_gaps();
    test_signed();
    test_reset_mid_emit();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
